// File: rtl/cfg_chain_loader_if.sv
// Host-side bus of the configuration chain loader: load control, bitstream
// write channel, readback channel and status.
interface cfg_chain_loader_if #(
    parameter int unsigned WORD_W = 4
) ();
    logic              start;
    logic              abort;
    logic [WORD_W-1:0] wr_data;
    logic              wr_valid;
    logic              wr_ready;
    logic [WORD_W-1:0] rd_data;
    logic              rd_valid;
    logic              rd_ready;
    logic              busy;
    logic              done;

    modport master (
        output start, abort, wr_data, wr_valid, rd_ready,
        input  wr_ready, rd_data, rd_valid, busy, done
    );

    modport slave (
        input  start, abort, wr_data, wr_valid, rd_ready,
        output wr_ready, rd_data, rd_valid, busy, done
    );
endinterface

// File: rtl/cfg_chain_loader.sv
// Buffers a host bitstream, shifts it into the prog_in/prog_out chain under prog_en,
// commits on prog_en fall and returns the chain's previous contents for readback.
module cfg_chain_loader #(
    parameter int unsigned CHAIN_LEN = 9,
    parameter int unsigned WORD_W    = 4
) (
    input  logic              i_prog_clk,
    input  logic              i_prog_rst_n,
    cfg_chain_loader_if.slave host,
    output logic              o_prog_in,
    output logic              o_prog_en,
    input  logic              i_chain_tail
);
    localparam int unsigned NWORDS = (CHAIN_LEN + WORD_W - 1) / WORD_W;
    localparam int unsigned CNT_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam int unsigned BIT_W  = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(NWORDS - 1);
    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(CHAIN_LEN - 1);

    typedef enum logic [2:0] {
        StIdle,
        StFill,
        StShift,
        StCommit,
        StDrain
    } state_e;

    state_e               r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [BIT_W-1:0]     r_bit_cnt;
    logic [CHAIN_LEN-1:0] r_buf;
    logic                 r_wr_ready;
    logic                 r_prog_in;
    logic                 r_prog_en;
    logic                 r_rd_valid;
    logic [WORD_W-1:0]    r_rd_data;
    logic                 r_busy;
    logic                 r_done;

    logic [CHAIN_LEN-1:0]           w_buf_wr;
    logic [NWORDS-1:0][WORD_W-1:0]  w_words;
    logic [CNT_W-1:0]               w_cnt_nxt;

    assign w_cnt_nxt = r_cnt + 1'b1;

    // Image with the incoming word merged in at slot r_cnt; pad bits are simply dropped.
    for (genvar i = 0; i < CHAIN_LEN; i++) begin : g_wr
        assign w_buf_wr[i] = (r_cnt == CNT_W'(i / WORD_W)) ? host.wr_data[i % WORD_W] : r_buf[i];
    end

    for (genvar k = 0; k < NWORDS; k++) begin : g_word
        for (genvar j = 0; j < WORD_W; j++) begin : g_bit
            if (k * WORD_W + j < CHAIN_LEN) begin : g_real
                assign w_words[k][j] = r_buf[k * WORD_W + j];
            end else begin : g_pad
                assign w_words[k][j] = 1'b0;
            end
        end
    end

    always_ff @(posedge i_prog_clk or negedge i_prog_rst_n) begin
        if (!i_prog_rst_n) begin
            r_state    <= StIdle;
            r_cnt      <= '0;
            r_bit_cnt  <= '0;
            r_buf      <= '0;
            r_wr_ready <= 1'b0;
            r_prog_in  <= 1'b0;
            r_prog_en  <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (host.start) begin
                        r_state    <= StFill;
                        r_cnt      <= '0;
                        r_wr_ready <= 1'b1;
                        r_busy     <= 1'b1;
                    end
                end
                StFill: begin
                    if (host.abort) begin
                        r_state    <= StIdle;
                        r_wr_ready <= 1'b0;
                        r_busy     <= 1'b0;
                    end else if (host.wr_valid) begin
                        r_buf <= w_buf_wr;
                        if (r_cnt == LAST_WORD) begin
                            r_wr_ready <= 1'b0;
                            r_bit_cnt  <= '0;
                            r_state    <= StShift;
                        end else begin
                            r_cnt <= w_cnt_nxt;
                        end
                    end
                end
                StShift: begin
                    // Buffer advances only on edges where the chain also shifts, so the
                    // captured tail bit stays aligned with the bit pushed into prog_in.
                    if (!r_prog_en) begin
                        r_prog_en <= 1'b1;
                        r_prog_in <= r_buf[CHAIN_LEN-1];
                    end else begin
                        r_buf     <= {r_buf[CHAIN_LEN-2:0], i_chain_tail};
                        r_prog_in <= r_buf[CHAIN_LEN-2];
                        if (r_bit_cnt == LAST_BIT) begin
                            r_prog_en <= 1'b0;
                            r_prog_in <= 1'b0;
                            r_done    <= 1'b1;
                            r_state   <= StCommit;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                end
                StCommit: begin
                    r_state    <= StDrain;
                    r_cnt      <= '0;
                    r_rd_valid <= 1'b1;
                    r_rd_data  <= w_words[0];
                end
                StDrain: begin
                    if (host.rd_ready) begin
                        if (r_cnt == LAST_WORD) begin
                            r_rd_valid <= 1'b0;
                            r_rd_data  <= '0;
                            r_busy     <= 1'b0;
                            r_state    <= StIdle;
                        end else begin
                            r_cnt     <= w_cnt_nxt;
                            r_rd_data <= w_words[w_cnt_nxt];
                        end
                    end
                end
                default: begin
                    r_state    <= StIdle;
                    r_wr_ready <= 1'b0;
                    r_prog_en  <= 1'b0;
                    r_rd_valid <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign host.wr_ready = r_wr_ready;
    assign host.rd_data  = r_rd_data;
    assign host.rd_valid = r_rd_valid;
    assign host.busy     = r_busy;
    assign host.done     = r_done;
    assign o_prog_in     = r_prog_in;
    assign o_prog_en     = r_prog_en;
endmodule

// File: tb/tb_cfg_chain_loader.sv
// Directed bench: drives cfg_chain_loader into a 9-bit model of three io_blocks
// (3 control bits each) and checks shift, commit and readback behaviour.
module tb_cfg_chain_loader;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic prog_in;
    logic prog_en;
    logic chain_tail;

    cfg_chain_loader_if #(.WORD_W(4)) host_if ();

    cfg_chain_loader #(
        .CHAIN_LEN(9),
        .WORD_W   (4)
    ) dut (
        .i_prog_clk  (clk),
        .i_prog_rst_n(rst_n),
        .host        (host_if),
        .o_prog_in   (prog_in),
        .o_prog_en   (prog_en),
        .i_chain_tail(chain_tail)
    );

    always #5 clk = ~clk;

    // Chain model: first-shifted bit ends at chain[8] (farthest block); block k
    // control is ctrl[3k+2:3k], latched once prog_en has dropped.
    logic [8:0] chain = '0;
    logic [8:0] ctrl  = '0;
    logic       en_d  = 1'b0;
    always @(posedge clk) begin
        if (prog_en) chain <= {chain[7:0], prog_in};
        en_d <= prog_en;
        if (en_d && !prog_en) ctrl <= chain;
    end
    assign chain_tail = chain[8];

    int          en_cycles = 0;
    int          done_cnt  = 0;
    logic [31:0] pin_seq   = '0;
    always @(negedge clk) begin
        if (prog_en === 1'b1) begin
            en_cycles = en_cycles + 1;
            pin_seq   = {pin_seq[30:0], prog_in};
        end
        if (host_if.done === 1'b1) done_cnt = done_cnt + 1;
    end

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [3:0] w0, input logic [3:0] w1, input logic [3:0] w2);
        host_if.start = 1'b1;
        tick();
        host_if.start    = 1'b0;
        host_if.wr_valid = 1'b1;
        host_if.wr_data  = w0;
        tick();
        host_if.wr_data = w1;
        tick();
        host_if.wr_data = w2;
        tick();
        host_if.wr_valid = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (host_if.done !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic drain(input string tag, input logic [3:0] e0, input logic [3:0] e1,
                         input logic [3:0] e2);
        logic [3:0] e[3];
        e[0] = e0;
        e[1] = e1;
        e[2] = e2;
        for (int k = 0; k < 3; k++) begin
            check({tag, "_rd_valid"}, 32'(host_if.rd_valid), 32'd1);
            check({tag, "_rd_data"}, 32'(host_if.rd_data), 32'(e[k]));
            host_if.rd_ready = 1'b1;
            tick();
            host_if.rd_ready = 1'b0;
        end
        check({tag, "_rd_valid_end"}, 32'(host_if.rd_valid), 32'd0);
        check({tag, "_busy_end"}, 32'(host_if.busy), 32'd0);
    endtask

    int en_base;
    int done_base;
    int lat;

    initial begin
        host_if.start    = 1'b0;
        host_if.abort    = 1'b0;
        host_if.wr_data  = '0;
        host_if.wr_valid = 1'b0;
        host_if.rd_ready = 1'b0;
        repeat (3) tick();
        check("rst_wr_ready", 32'(host_if.wr_ready), 32'd0);
        check("rst_prog_in", 32'(prog_in), 32'd0);
        check("rst_prog_en", 32'(prog_en), 32'd0);
        check("rst_rd_valid", 32'(host_if.rd_valid), 32'd0);
        check("rst_rd_data", 32'(host_if.rd_data), 32'd0);
        check("rst_busy", 32'(host_if.busy), 32'd0);
        check("rst_done", 32'(host_if.done), 32'd0);
        rst_n = 1'b1;
        tick();

        // Load 1: image 0x1A5 into an all-zero chain; start and abort together.
        en_base   = en_cycles;
        done_base = done_cnt;
        host_if.abort = 1'b1;
        host_if.start = 1'b1;
        tick();
        host_if.abort = 1'b0;
        host_if.start = 1'b0;
        check("l1_wr_ready", 32'(host_if.wr_ready), 32'd1);
        check("l1_busy", 32'(host_if.busy), 32'd1);
        host_if.wr_valid = 1'b1;
        host_if.wr_data  = 4'h5;
        tick();
        host_if.wr_data = 4'hA;
        tick();
        host_if.wr_data = 4'h1;
        tick();
        host_if.wr_valid = 1'b0;
        check("l1_wr_ready_fall", 32'(host_if.wr_ready), 32'd0);
        wait_done(lat);
        check("l1_latency", 32'(1 + 3 + lat), 32'd14);
        check("l1_done_prog_en", 32'(prog_en), 32'd0);
        tick();
        check("l1_en_cycles", 32'(en_cycles - en_base), 32'd9);
        check("l1_prog_in_seq", pin_seq & 32'h1FF, 32'h1A5);
        check("l1_done_count", 32'(done_cnt - done_base), 32'd1);
        check("l1_blk0", 32'(ctrl[2:0]), 32'h5);
        check("l1_blk1", 32'(ctrl[5:3]), 32'h4);
        check("l1_blk2", 32'(ctrl[8:6]), 32'h6);
        drain("l1", 4'h0, 4'h0, 4'h0);

        // Load 2: image 0x0F3; readback returns the first image.
        en_base = en_cycles;
        do_load(4'h3, 4'hF, 4'h0);
        wait_done(lat);
        check("l2_done", 32'(host_if.done), 32'd1);
        tick();
        check("l2_en_cycles", 32'(en_cycles - en_base), 32'd9);
        check("l2_prog_in_seq", pin_seq & 32'h1FF, 32'h0F3);
        check("l2_ctrl", 32'(ctrl), 32'h0F3);
        drain("l2", 4'h5, 4'hA, 4'h1);

        // Abort after two of three words.
        en_base   = en_cycles;
        done_base = done_cnt;
        host_if.start = 1'b1;
        tick();
        host_if.start    = 1'b0;
        host_if.wr_valid = 1'b1;
        host_if.wr_data  = 4'h7;
        tick();
        host_if.wr_data = 4'h8;
        tick();
        host_if.wr_data = 4'h9;
        host_if.abort   = 1'b1;
        tick();
        host_if.abort    = 1'b0;
        host_if.wr_valid = 1'b0;
        check("ab_busy", 32'(host_if.busy), 32'd0);
        check("ab_wr_ready", 32'(host_if.wr_ready), 32'd0);
        repeat (12) tick();
        check("ab_en_cycles", 32'(en_cycles - en_base), 32'd0);
        check("ab_done_count", 32'(done_cnt - done_base), 32'd0);
        check("ab_ctrl", 32'(ctrl), 32'h0F3);

        // Write backpressure 1,0,1,0,1 for image 0x13C, start pulsed during SHIFT.
        en_base   = en_cycles;
        done_base = done_cnt;
        host_if.start = 1'b1;
        tick();
        host_if.start = 1'b0;
        host_if.wr_valid = 1'b1; host_if.wr_data = 4'hC; tick();
        host_if.wr_valid = 1'b0; host_if.wr_data = 4'hF; tick();
        host_if.wr_valid = 1'b1; host_if.wr_data = 4'h3; tick();
        host_if.wr_valid = 1'b0; host_if.wr_data = 4'hF; tick();
        check("bp_wr_ready_hold", 32'(host_if.wr_ready), 32'd1);
        check("bp_no_shift_yet", 32'(prog_en), 32'd0);
        host_if.wr_valid = 1'b1; host_if.wr_data = 4'h1; tick();
        host_if.wr_valid = 1'b0;
        check("bp_wr_ready_fall", 32'(host_if.wr_ready), 32'd0);
        tick();
        check("bp_shift_start", 32'(prog_en), 32'd1);
        tick();
        host_if.start = 1'b1;
        tick();
        host_if.start = 1'b0;
        wait_done(lat);
        check("bp_done", 32'(host_if.done), 32'd1);
        tick();
        check("bp_en_cycles", 32'(en_cycles - en_base), 32'd9);
        check("bp_prog_in_seq", pin_seq & 32'h1FF, 32'h13C);
        check("bp_ctrl", 32'(ctrl), 32'h13C);
        // Read backpressure: first word must hold for 5 cycles.
        for (int i = 0; i < 5; i++) begin
            check("rbp_rd_valid", 32'(host_if.rd_valid), 32'd1);
            check("rbp_rd_data", 32'(host_if.rd_data), 32'h3);
            tick();
        end
        drain("rbp", 4'h3, 4'hF, 4'h0);
        repeat (15) tick();
        check("sb_done_count", 32'(done_cnt - done_base), 32'd1);
        check("sb_busy_idle", 32'(host_if.busy), 32'd0);

        // Reset during SHIFT drops prog_en without waiting for the clock.
        done_base = done_cnt;
        do_load(4'h1, 4'h2, 4'h3);
        repeat (3) tick();
        check("rs_prog_en_pre", 32'(prog_en), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rs_prog_en_async", 32'(prog_en), 32'd0);
        check("rs_busy", 32'(host_if.busy), 32'd0);
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        check("rs_stay_idle", 32'(host_if.busy), 32'd0);
        check("rs_no_done", 32'(done_cnt - done_base), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
